// File: rtl/alu_seq_if.sv
// Handshake and data bundle between the control unit and the sequential ALU.
// The control unit drives the request side; the ALU returns busy/done and the
// registered result, product high half, status flags and illegal-op marker.
interface alu_seq_if #(
    parameter int W = 32
);
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         stswrite;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic [3:0]   status;
    logic         illegal;

    modport master (
        output start, op, a, b, stswrite,
        input  busy, done, result, result_hi, status, illegal
    );

    modport slave (
        input  start, op, a, b, stswrite,
        output busy, done, result, result_hi, status, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Registered, parametrised ALU with a start/busy/done handshake.
// Single-cycle ops complete on the edge after accept; MUL runs a shift-add
// sequence of W iterations so the control unit can stall the pipeline.
// status = {carry, zero, negative, overflow}, written only on done when the
// accepted request had stswrite set.
module alu_seq #(
    parameter int W = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    alu_seq_if.slave   bus
);
    localparam int SW = $clog2(W);
    localparam logic [SW-1:0] LAST_ITER = SW'(W - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t         state;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [SW-1:0]  iter;
    logic           stsLatched;

    logic [W:0]     addSum;
    logic [W:0]     subDiff;
    logic           addOvf;
    logic           subOvf;

    logic [W-1:0]   aluRes;
    logic           aluCarry;
    logic           aluOvf;
    logic           aluIllegal;

    logic [W:0]     mulSum;
    logic [2*W-1:0] mulNext;
    logic [2*W-1:0] mulFirst;

    assign addSum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign subDiff = {1'b0, bus.a} + {1'b0, ~bus.b} + {{W{1'b0}}, 1'b1};
    assign addOvf  = (bus.a[W-1] == bus.b[W-1]) && (addSum[W-1] != bus.a[W-1]);
    assign subOvf  = (bus.a[W-1] != bus.b[W-1]) && (subDiff[W-1] != bus.a[W-1]);

    // One shift-add step: conditionally add the multiplicand into the upper
    // half with a W+1-bit sum so its carry survives the right shift.
    assign mulSum  = {1'b0, acc[2*W-1:W]} + (mplier[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    assign mulNext = {mulSum, acc[W-1:1]};

    // The first iteration is folded into the accept edge (accumulator starts
    // cleared), so the W-th iteration lands W cycles after accept.
    assign mulFirst = {(bus.b[0] ? {1'b0, bus.a} : {(W+1){1'b0}}), {(W-1){1'b0}}};

    // Combinational result and flags for the single-cycle operations.
    always_comb begin
        aluRes     = '0;
        aluCarry   = 1'b0;
        aluOvf     = 1'b0;
        aluIllegal = 1'b0;
        case (bus.op)
            OP_AND: aluRes = bus.a & bus.b;
            OP_OR:  aluRes = bus.a | bus.b;
            OP_XOR: aluRes = bus.a ^ bus.b;
            OP_ADD: begin
                aluRes   = addSum[W-1:0];
                aluCarry = addSum[W];
                aluOvf   = addOvf;
            end
            OP_SUB: begin
                aluRes   = subDiff[W-1:0];
                aluCarry = subDiff[W];
                aluOvf   = subOvf;
            end
            OP_SLT: aluRes = {{(W-1){1'b0}}, subDiff[W-1] ^ subOvf};
            OP_SLL: aluRes = bus.a << bus.b[SW-1:0];
            OP_SRL: aluRes = bus.a >> bus.b[SW-1:0];
            default: aluIllegal = 1'b1;
        endcase
    end

    // Handshake FSM, multiply sequencer and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.result    <= '0;
            bus.result_hi <= '0;
            bus.status    <= 4'b0000;
            bus.illegal   <= 1'b0;
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            iter          <= '0;
            stsLatched    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        if (bus.op == OP_MUL) begin
                            state      <= S_MUL;
                            bus.busy   <= 1'b1;
                            mcand      <= bus.a;
                            mplier     <= bus.b >> 1;
                            acc        <= mulFirst;
                            iter       <= SW'(1);
                            stsLatched <= bus.stswrite;
                        end else begin
                            bus.done      <= 1'b1;
                            bus.result    <= aluRes;
                            bus.result_hi <= '0;
                            bus.illegal   <= aluIllegal;
                            if (bus.stswrite) begin
                                bus.status <= aluIllegal ? 4'b0100 :
                                              {aluCarry, (aluRes == '0), aluRes[W-1], aluOvf};
                            end
                        end
                    end
                end
                S_MUL: begin
                    acc    <= mulNext;
                    mplier <= mplier >> 1;
                    iter   <= iter + SW'(1);
                    if (iter == LAST_ITER) begin
                        state         <= S_IDLE;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.result    <= mulNext[W-1:0];
                        bus.result_hi <= mulNext[2*W-1:W];
                        bus.illegal   <= 1'b0;
                        if (stsLatched) begin
                            bus.status <= {1'b0, (mulNext == '0), mulNext[W-1], 1'b0};
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed checking of alu_seq at W=32 against a plain
// arithmetic reference model of the operation set and status rules.
module tb_alu_seq;
    localparam int W = 32;

    logic clk;
    logic reset_n;
    int   assertCount;
    int   failCount;
    logic [3:0] expStatus;

    alu_seq_if #(.W(W)) bus ();

    alu_seq #(.W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference model written directly from the operation definitions.
    task automatic modelOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic [31:0] hi,
                           output logic [3:0] st, output logic ill);
        longint sa, sb, sd;
        longint unsigned ua, ub, prod;
        logic carry, ovf, zero;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        res = 0; hi = 0; carry = 0; ovf = 0; ill = 0; zero = 0;
        case (op)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0011: res = a ^ b;
            4'b0010: begin
                prod  = ua + ub;
                res   = prod[31:0];
                carry = (prod >= 64'd4294967296);
                sd    = sa + sb;
                ovf   = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
            end
            4'b0110: begin
                res   = a - b;
                carry = (ua >= ub);
                sd    = sa - sb;
                ovf   = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
            end
            4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
            4'b0101: res = a << (b % 32);
            4'b0100: res = a >> (b % 32);
            4'b1000: begin
                prod = ua * ub;
                res  = prod[31:0];
                hi   = prod[63:32];
            end
            default: ill = 1;
        endcase
        zero = (res == 0) && (hi == 0);
        st = ill ? 4'b0100 : {carry, zero, res[31], ovf};
    endtask

    // Issue one request and follow it to done, checking latency, busy,
    // outputs and the done pulse. Optionally pulse a stray start or drop
    // reset partway through.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic sw, input int injectAt, input int abortAt);
        logic [31:0] eRes, eHi;
        logic [3:0]  eSt;
        logic        eIll;
        int cycles, busyCycles, expLat;
        bit aborted;
        modelOp(op, a, b, eRes, eHi, eSt, eIll);
        expLat = (op == 4'b1000) ? W : 1;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.stswrite = sw;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cycles = 0; busyCycles = 0; aborted = 0;
        while (1) begin
            @(negedge clk);
            cycles++;
            bus.start = 1'b0;
            if (bus.busy) busyCycles++;
            if (bus.done) break;
            if (cycles >= 3 * W) break;
            if (injectAt == cycles) begin
                bus.start = 1'b1; bus.op = 4'b0010; bus.a = $urandom; bus.b = $urandom; bus.stswrite = 1'b1;
            end
            if (abortAt == cycles) begin
                reset_n = 1'b0;
                #1;
                checkOutput("abort_busy", 64'(bus.busy), 64'd0);
                checkOutput("abort_done", 64'(bus.done), 64'd0);
                checkOutput("abort_result", 64'(bus.result), 64'd0);
                checkOutput("abort_result_hi", 64'(bus.result_hi), 64'd0);
                checkOutput("abort_status", 64'(bus.status), 64'd0);
                checkOutput("abort_illegal", 64'(bus.illegal), 64'd0);
                expStatus = 4'b0000;
                @(negedge clk);
                reset_n = 1'b1;
                aborted = 1;
                break;
            end
        end
        if (!aborted) begin
            if (!bus.done) begin
                checkOutput("done_timeout", 64'(bus.done), 64'd1);
            end else begin
                if (sw) expStatus = eSt;
                checkOutput("latency", 64'(cycles), 64'(expLat));
                checkOutput("busy_cycles", 64'(busyCycles), 64'(expLat - 1));
                checkOutput("result", 64'(bus.result), 64'(eRes));
                checkOutput("result_hi", 64'(bus.result_hi), 64'(eHi));
                checkOutput("illegal", 64'(bus.illegal), 64'(eIll));
                checkOutput("status", 64'(bus.status), 64'(expStatus));
                @(negedge clk);
                checkOutput("done_pulse", 64'(bus.done), 64'd0);
                checkOutput("result_hold", 64'(bus.result), 64'(eRes));
            end
        end
    endtask

    logic [31:0] corner [4];
    logic [3:0]  opTable [11];

    function automatic logic [31:0] pickOperand();
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] eRes, eHi, ra, rb;
        logic [3:0]  eSt, rop;
        logic        eIll, rsw;
        assertCount = 0;
        failCount   = 0;
        expStatus   = 4'b0000;
        corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;
        opTable[0] = 4'b0000; opTable[1] = 4'b0001; opTable[2] = 4'b0011;
        opTable[3] = 4'b0010; opTable[4] = 4'b0110; opTable[5] = 4'b0111;
        opTable[6] = 4'b0101; opTable[7] = 4'b0100; opTable[8] = 4'b1111;
        opTable[9] = 4'b1001; opTable[10] = 4'b1000;

        bus.start = 1'b0; bus.op = 4'b0; bus.a = '0; bus.b = '0; bus.stswrite = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_result", 64'(bus.result), 64'd0);
        checkOutput("reset_result_hi", 64'(bus.result_hi), 64'd0);
        checkOutput("reset_status", 64'(bus.status), 64'd0);
        checkOutput("reset_illegal", 64'(bus.illegal), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed cases");
        applyStimulus(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 0, 0);
        checkOutput("add_ovf_status", 64'(bus.status), 64'h3);
        applyStimulus(4'b0110, 32'd5, 32'd5, 1'b1, 0, 0);
        checkOutput("sub_eq_status", 64'(bus.status), 64'hC);
        applyStimulus(4'b0110, 32'd3, 32'd5, 1'b0, 0, 0);
        checkOutput("sub_nowrite_result", 64'(bus.result), 64'hFFFF_FFFE);
        checkOutput("sub_nowrite_status", 64'(bus.status), 64'hC);
        applyStimulus(4'b0111, 32'h8000_0000, 32'h0000_0001, 1'b1, 0, 0);
        checkOutput("slt_result", 64'(bus.result), 64'd1);
        applyStimulus(4'b0100, 32'h8000_0000, 32'h0000_001F, 1'b1, 0, 0);
        checkOutput("srl_result", 64'(bus.result), 64'd1);
        applyStimulus(4'b0101, 32'h1234_5678, 32'h0000_0020, 1'b1, 0, 0);
        checkOutput("sll_wrap_result", 64'(bus.result), 64'h1234_5678);
        applyStimulus(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 7, 0);
        checkOutput("mul_hi", 64'(bus.result_hi), 64'hFFFF_FFFE);
        checkOutput("mul_lo", 64'(bus.result), 64'h0000_0001);
        applyStimulus(4'b1000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0, 10);
        applyStimulus(4'b0010, 32'd2, 32'd3, 1'b1, 0, 0);
        checkOutput("add_after_reset", 64'(bus.result), 64'd5);
        applyStimulus(4'b1111, 32'hDEAD_BEEF, 32'h1, 1'b1, 0, 0);
        checkOutput("illegal_set", 64'(bus.illegal), 64'd1);
        checkOutput("illegal_status", 64'(bus.status), 64'h4);
        applyStimulus(4'b0001, 32'hF0, 32'h0F, 1'b1, 0, 0);
        checkOutput("illegal_cleared", 64'(bus.illegal), 64'd0);

        $display("[TB] back-to-back single-cycle ops");
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            rop = opTable[$urandom_range(0, 9)];
            ra = pickOperand(); rb = pickOperand(); rsw = 1'($urandom_range(0, 1));
            bus.start = 1'b1; bus.op = rop; bus.a = ra; bus.b = rb; bus.stswrite = rsw;
            modelOp(rop, ra, rb, eRes, eHi, eSt, eIll);
            if (rsw) expStatus = eSt;
            @(posedge clk);
            #1;
            checkOutput("b2b_done", 64'(bus.done), 64'd1);
            checkOutput("b2b_result", 64'(bus.result), 64'(eRes));
            checkOutput("b2b_status", 64'(bus.status), 64'(expStatus));
        end
        bus.start = 1'b0;

        $display("[TB] random ops");
        for (int i = 0; i < 60; i++) begin
            rop = ($urandom_range(0, 9) == 0) ? 4'b1000 : opTable[$urandom_range(0, 9)];
            applyStimulus(rop, pickOperand(), pickOperand(), 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
